// File: rtl/lb_uart_pkg.sv
// lb_uart_pkg: shared state encoding and byte width for the UART transmit arbiter slice
package lb_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} lb_state_e;
  localparam int LB_DATA_W = 8;
endpackage

// File: rtl/lb_rr_priority.sv
// lb_rr_priority: combinational rotating-priority picker, scanning upward from last_i+1 with wrap
module lb_rr_priority #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic         any_o,
  output logic [W-1:0] winner_o
);
  // Walk from the farthest slot down to the nearest so the nearest hit wins
  always_comb begin
    any_o = |req_i;
    winner_o = '0;
    for (int k = N; k >= 1; k--)
      if (req_i[(int'(last_i) + k) % N]) winner_o = W'((int'(last_i) + k) % N);
  end
endmodule

// File: rtl/lb_uart_tx_arbiter.sv
// lb_uart_tx_arbiter: round-robin sharing of one UART Tx core among NUM_REQ byte sources.
// Optional LB_UART_TX_ARB_LOCK_EN adds a per-requester lock that keeps multi-byte messages contiguous.
module lb_uart_tx_arbiter
  import lb_uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = LB_DATA_W,
  localparam int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
`ifdef LB_UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        ack,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done
);
  lb_state_e            state_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 tx_start_q;
  logic [DATA_W-1:0]    tx_data_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [GRANT_W-1:0]   last_q;
  logic [NUM_REQ-1:0]   req_m;
  logic                 any_req;
  logic [GRANT_W-1:0]   winner;
`ifdef LB_UART_TX_ARB_LOCK_EN
  logic                 lock_valid_q;
  logic [GRANT_W-1:0]   lock_owner_q;
  logic                 lock_hold;
  // A held lock hides every requester except the owner
  assign lock_hold = lock_valid_q & lock[lock_owner_q];
  assign req_m = lock_hold ? req & (NUM_REQ'(1) << lock_owner_q) : req;
`else
  assign req_m = req;
`endif
  lb_rr_priority #(.N(NUM_REQ), .W(GRANT_W)) u_pick (
    .req_i   (req_m),
    .last_i  (last_q),
    .any_o   (any_req),
    .winner_o(winner)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
      grant_q <= '0;
      last_q <= GRANT_W'(NUM_REQ - 1);
`ifdef LB_UART_TX_ARB_LOCK_EN
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      ack_q <= '0;
      case (state_q)
        IDLE: begin
`ifdef LB_UART_TX_ARB_LOCK_EN
          lock_valid_q <= lock_hold;
`endif
          if (any_req) begin
            tx_data_q <= data_in[winner*DATA_W +: DATA_W];
            grant_q <= winner;
            tx_start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: state_q <= WAIT;
        WAIT: if (tx_done) begin
          ack_q[grant_q] <= 1'b1;
          state_q <= ACK;
        end
        default: begin
          last_q <= grant_q;
`ifdef LB_UART_TX_ARB_LOCK_EN
          lock_valid_q <= lock[grant_q];
          lock_owner_q <= grant_q;
`endif
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign ack = ack_q;
  assign grant_id = grant_q;
  assign busy = state_q != IDLE;
  assign tx_start = tx_start_q;
  assign tx_data = tx_data_q;
endmodule

// File: tb/tb_lb_uart_tx_arbiter.sv
// tb_lb_uart_tx_arbiter: scoreboard bench; stimulus queues expected frames/acks, a monitor pops and compares
module tb_lb_uart_tx_arbiter;
  typedef struct {logic [1:0] g; logic [7:0] d;} frame_t;
  logic        clk = 0;
  logic        reset = 1;
  logic [3:0]  req = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 0;
  logic        tx_auto = 1;
  frame_t      exp_q[$];
  logic [3:0]  ack_q[$];
  int          n_pass = 0;
  int          n_total = 0;
`ifdef LB_UART_TX_ARB_LOCK_EN
  logic [3:0]  lock = '0;
`endif
  lb_uart_tx_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
`ifdef LB_UART_TX_ARB_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .grant_id(grant_id), .busy(busy),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic push(input logic [1:0] g, input logic [7:0] d, input bit with_ack);
    frame_t f;
    f.g = g;
    f.d = d;
    exp_q.push_back(f);
    if (with_ack) ack_q.push_back(4'b0001 << g);
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || ack_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'd1, 32'd0);
  endtask
  task automatic wait_ack(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[i] && n < 3000);
    if (!ack[i]) chk("ack_timeout", 32'd1, 32'd0);
  endtask
  // Tx core model: done pulse 20 cycles after each start
  initial forever begin
    @(negedge clk);
    if (tx_auto && tx_start) begin
      repeat (20) @(negedge clk);
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
    end
  end
  // Monitor: compare each start and each ack against the scoreboard; requesters drop req after ack
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      if (exp_q.size() == 0) chk("unexpected_tx_start", 32'd1, 32'd0);
      else begin
        frame_t f;
        f = exp_q.pop_front();
        chk("start_grant", 32'(grant_id), 32'(f.g));
        chk("start_data", 32'(tx_data), 32'(f.d));
      end
    end
    if (ack != 0) begin
      if (ack_q.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
      else chk("ack_vec", 32'(ack), 32'(ack_q.pop_front()));
      req = req & ~ack;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 0;
    @(negedge clk);
    // single request
    data_in[15:8] = 8'hA5;
    req = 4'b0010;
    push(1, 8'hA5, 1);
    @(negedge clk);
    chk("single_latency", 32'(tx_start), 1);
    drain();
    chk("single_busy_done", 32'(busy), 0);
    chk("single_req_cleared", 32'(req), 0);
    // round robin from reset
    reset = 1;
    @(negedge clk);
    reset = 0;
    data_in = 32'h13121110;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) push(2'(i), 8'h10 + 8'(i), 1);
    drain();
    // wrap: last grant is 3
    req = 4'b1001;
    push(0, 8'h10, 1);
    push(3, 8'h13, 1);
    drain();
    // spurious tx_done in IDLE, START, and req drop / data change during WAIT
    tx_auto = 0;
    tx_done = 1;
    @(negedge clk);
    tx_done = 0;
    @(negedge clk);
    chk("spur_idle_busy", 32'(busy), 0);
    chk("spur_idle_ack", 32'(ack), 0);
    data_in[23:16] = 8'h5A;
    req = 4'b0100;
    push(2, 8'h5A, 1);
    @(negedge clk);
    tx_done = 1;
    @(negedge clk);
    tx_done = 0;
    req = 4'b0000;
    data_in[23:16] = 8'hFF;
    repeat (5) @(negedge clk);
    chk("spur_start_busy", 32'(busy), 1);
    chk("spur_start_ack", 32'(ack), 0);
    chk("wait_data_stable", 32'(tx_data), 32'h5A);
    tx_done = 1;
    @(negedge clk);
    tx_done = 0;
    drain();
    // reset mid-frame
    data_in[15:8] = 8'h77;
    req = 4'b0010;
    push(1, 8'h77, 0);
    repeat (4) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 1);
    reset = 1;
    @(negedge clk);
    chk("mid_tx_start", 32'(tx_start), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_ack", 32'(ack), 0);
    chk("mid_grant", 32'(grant_id), 0);
    chk("mid_tx_data", 32'(tx_data), 0);
    data_in[7:0] = 8'hC3;
    req = 4'b0001;
    tx_auto = 1;
    push(0, 8'hC3, 1);
    reset = 0;
    drain();
`ifdef LB_UART_TX_ARB_LOCK_EN
    // requester 2 holds the lock for three bytes while requester 0 waits
    lock = 4'b0100;
    data_in[23:16] = 8'h20;
    data_in[7:0] = 8'h30;
    req = 4'b0101;
    push(2, 8'h20, 1);
    push(2, 8'h21, 1);
    push(2, 8'h22, 1);
    push(0, 8'h30, 1);
    for (int b = 0; b < 3; b++) begin
      wait_ack(2);
      @(negedge clk);
      if (b < 2) begin
        data_in[23:16] = 8'h21 + 8'(b);
        req[2] = 1'b1;
      end else lock = 4'b0000;
    end
    drain();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
